// File: rtl/dmem_dump_arbiter_pkg.sv
// Shared constants and types for the data-memory dump arbiter.
// Word geometry, FSM encoding and starve-counter sizing.
package dmem_dump_arbiter_pkg;

    localparam int XLEN_32B   = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int STARVE_DEF = 8;
    localparam int WORD_OFS_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } dump_state_e;

    function automatic int starve_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_port_mux.sv
// Per-cycle grant select between pipeline and dump scanner.
// Pipeline wins unless the dump has been starved STARVE_LIMIT times.
module dmem_port_mux
    import dmem_dump_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pl_req,
    input  logic i_dump_pend,
    output logic o_grant_pl,
    output logic o_grant_dump,
    output logic o_pl_stall
);

    localparam int SW = starve_width(STARVE_LIMIT);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          force_dump;

    always_comb begin
        force_dump   = i_dump_pend && (starve_q == SW'(STARVE_LIMIT));
        o_grant_dump = i_dump_pend && (!i_pl_req || force_dump);
        o_grant_pl   = i_pl_req && !force_dump;
        o_pl_stall   = i_pl_req && force_dump;
        // Counter never passes the limit: at the limit the dump is forced.
        starve_d = '0;
        if (i_dump_pend && !o_grant_dump) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/dmem_dump_arbiter.sv
// Shares the data memory between the MEM stage and a debug dump scanner.
// Scanner streams words [lo,hi) to a valid/ready sink.
module dmem_dump_arbiter
    import dmem_dump_arbiter_pkg::*;
#(
    parameter int XLEN         = XLEN_32B,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = STARVE_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pl_req,
    input  logic              i_pl_we,
    input  logic [ADDR_W-1:0] i_pl_addr,
    input  logic [XLEN-1:0]   i_pl_wdata,
    input  logic [XLEN/8-1:0] i_pl_be,
    output logic              o_pl_stall,
    output logic [XLEN-1:0]   o_pl_rdata,
    output logic              o_pl_rvalid,
    input  logic              i_dump_start,
    input  logic [ADDR_W-1:0] i_dump_lo,
    input  logic [ADDR_W-1:0] i_dump_hi,
    output logic              o_dump_busy,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic [ADDR_W-1:0] o_dump_addr,
    output logic [XLEN-1:0]   o_dump_data,
    output logic              o_dump_done,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_be,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK =
        {{(ADDR_W-WORD_OFS_W){1'b1}}, {WORD_OFS_W{1'b0}}};

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              inflight_q, inflight_d;
    logic              hold_valid_q, hold_valid_d;
    logic              done_q, done_d;
    logic              pl_rd_q, pl_rd_d;

    logic              dump_pend;
    logic              grant_pl;
    logic              grant_dump;
    logic [ADDR_W-1:0] lo_al;
    logic [ADDR_W-1:0] hi_al;

    assign dump_pend = (state_q == ST_SCAN) && !hold_valid_q && !inflight_q;
    assign lo_al     = i_dump_lo & ALIGN_MASK;
    assign hi_al     = i_dump_hi & ALIGN_MASK;

    dmem_port_mux #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_mux (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pl_req     (i_pl_req),
        .i_dump_pend  (dump_pend),
        .o_grant_pl   (grant_pl),
        .o_grant_dump (grant_dump),
        .o_pl_stall   (o_pl_stall)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        end_d        = end_q;
        addr_d       = addr_q;
        data_d       = data_q;
        inflight_d   = inflight_q;
        hold_valid_d = hold_valid_q;
        done_d       = 1'b0;
        pl_rd_d      = grant_pl && !i_pl_we;
        unique case (state_q)
            ST_IDLE: begin
                if (i_dump_start) begin
                    ptr_d = lo_al;
                    end_d = hi_al;
                    if (lo_al >= hi_al) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (grant_dump) begin
                    inflight_d = 1'b1;
                end
                if (inflight_q) begin
                    inflight_d   = 1'b0;
                    hold_valid_d = 1'b1;
                    addr_d       = ptr_q;
                    data_d       = i_mem_rdata;
                    ptr_d        = ptr_q + ADDR_W'(4);
                end
                if (hold_valid_q && i_dump_ready) begin
                    hold_valid_d = 1'b0;
                    if (ptr_q == end_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            end_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            done_q       <= 1'b0;
            pl_rd_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            end_q        <= end_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            inflight_q   <= inflight_d;
            hold_valid_q <= hold_valid_d;
            done_q       <= done_d;
            pl_rd_q      <= pl_rd_d;
        end
    end

    always_comb begin
        o_mem_en    = grant_pl || grant_dump;
        o_mem_we    = grant_pl && i_pl_we;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = '0;
        if (grant_dump) begin
            o_mem_addr = ptr_q;
        end else if (grant_pl) begin
            o_mem_addr  = i_pl_addr;
            o_mem_wdata = i_pl_wdata;
            o_mem_be    = i_pl_be;
        end
    end

    assign o_pl_rvalid  = pl_rd_q;
    assign o_pl_rdata   = pl_rd_q ? i_mem_rdata : '0;
    assign o_dump_busy  = (state_q != ST_IDLE);
    assign o_dump_valid = hold_valid_q;
    assign o_dump_addr  = addr_q;
    assign o_dump_data  = data_q;
    assign o_dump_done  = done_q;

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Directed bench for dmem_dump_arbiter with a small synchronous RAM model.
// Word n of the RAM holds 0x1000_0000+n, except word 16 = 0xDEADBEEF.
module tb_dmem_dump_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pl_req, pl_we;
    logic [31:0] pl_addr, pl_wdata;
    logic [3:0]  pl_be;
    logic        pl_stall, pl_rvalid;
    logic [31:0] pl_rdata;
    logic        dump_start, dump_ready;
    logic [31:0] dump_lo, dump_hi;
    logic        dump_busy, dump_valid, dump_done;
    logic [31:0] dump_addr, dump_data;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic [31:0] mem [0:63];
    int checks = 0;
    int fails  = 0;
    int dc;

    always #5 clk = ~clk;

    dmem_dump_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pl_req     (pl_req),
        .i_pl_we      (pl_we),
        .i_pl_addr    (pl_addr),
        .i_pl_wdata   (pl_wdata),
        .i_pl_be      (pl_be),
        .o_pl_stall   (pl_stall),
        .o_pl_rdata   (pl_rdata),
        .o_pl_rvalid  (pl_rvalid),
        .i_dump_start (dump_start),
        .i_dump_lo    (dump_lo),
        .i_dump_hi    (dump_hi),
        .o_dump_busy  (dump_busy),
        .o_dump_valid (dump_valid),
        .i_dump_ready (dump_ready),
        .o_dump_addr  (dump_addr),
        .o_dump_data  (dump_data),
        .o_dump_done  (dump_done),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_be     (mem_be),
        .i_mem_rdata  (mem_rdata)
    );

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= (i == 16) ? 32'hDEAD_BEEF : 32'h1000_0000 + i;
            end
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[7:2]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expw(input logic [31:0] a, input bit patched);
        if (patched && a == 32'h8) return 32'h1000_5678;
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + {26'd0, a[7:2]};
    endfunction

    // Starts a scan and drains it with ready=1; optional store to 0x8 in cycle 1.
    task automatic scan(input logic [31:0] lo, input logic [31:0] hi, input int nexp,
                        input bit st, output int done_cyc);
        logic [31:0] ea;
        int n;
        dump_lo = lo;
        dump_hi = hi;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        if (st) begin
            pl_req = 1'b1; pl_we = 1'b1; pl_addr = 32'h8;
            pl_wdata = 32'h1234_5678; pl_be = 4'b0011;
            #1;
            chk("store_stall", {63'd0, pl_stall}, 64'd0);
            chk("store_we", {63'd0, mem_we}, 64'd1);
            chk("store_be", {60'd0, mem_be}, 64'h3);
        end
        ea = lo;
        n = 0;
        done_cyc = -1;
        for (int c = 1; c <= 60; c++) begin
            if (dump_valid && dump_ready) begin
                chk("scan_addr", {32'd0, dump_addr}, {32'd0, ea});
                chk("scan_data", {32'd0, dump_data}, {32'd0, expw(ea, st)});
                ea = ea + 32'd4;
                n++;
            end
            if (dump_done) begin
                done_cyc = c;
                break;
            end
            step();
            if (c == 1) begin
                pl_req = 1'b0; pl_we = 1'b0;
            end
        end
        chk("scan_words", 64'(n), 64'(nexp));
        chk("scan_done_seen", {63'd0, done_cyc != -1}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; pl_req = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_wdata = '0;
        pl_be = '0; dump_start = 1'b0; dump_lo = '0; dump_hi = '0; dump_ready = 1'b1;
        step(); step(); step();
        chk("rst_valid", {63'd0, dump_valid}, 64'd0);
        chk("rst_busy", {63'd0, dump_busy}, 64'd0);
        chk("rst_done", {63'd0, dump_done}, 64'd0);
        chk("rst_stall", {63'd0, pl_stall}, 64'd0);
        chk("rst_rvalid", {63'd0, pl_rvalid}, 64'd0);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_dump_addr", {32'd0, dump_addr}, 64'd0);
        chk("rst_dump_data", {32'd0, dump_data}, 64'd0);
        rst = 1'b0;
        step();

        // 1: plain scan of four words
        scan(32'h0, 32'h10, 4, 1'b0, dc);
        chk("t1_done_cycle", 64'(dc), 64'd13);
        step();
        chk("t1_done_pulse", {63'd0, dump_done}, 64'd0);
        chk("t1_busy_after", {63'd0, dump_busy}, 64'd0);

        // 2: empty range
        dump_lo = 32'h20; dump_hi = 32'h23; dump_start = 1'b1;
        #1;
        chk("t2_no_mem_c0", {63'd0, mem_en}, 64'd0);
        step();
        dump_start = 1'b0;
        chk("t2_done", {63'd0, dump_done}, 64'd1);
        chk("t2_no_mem_c1", {63'd0, mem_en}, 64'd0);
        step();
        chk("t2_done_drop", {63'd0, dump_done}, 64'd0);
        chk("t2_busy_low", {63'd0, dump_busy}, 64'd0);

        // 3: pipeline load held every cycle, forced dump slots
        pl_req = 1'b1; pl_we = 1'b0; pl_addr = 32'h40; pl_be = 4'hF;
        dump_lo = 32'h0; dump_hi = 32'h8; dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            chk("t3_stall", {63'd0, pl_stall}, {63'd0, (c == 9 || c == 20)});
            if (c == 2) begin
                chk("t3_rvalid", {63'd0, pl_rvalid}, 64'd1);
                chk("t3_rdata", {32'd0, pl_rdata}, 64'hDEAD_BEEF);
            end
            if (c == 10) chk("t3_no_rvalid", {63'd0, pl_rvalid}, 64'd0);
            if (c == 9) chk("t3_slot0_addr", {32'd0, mem_addr}, 64'h0);
            if (c == 20) chk("t3_slot1_addr", {32'd0, mem_addr}, 64'h4);
            if (c == 11) begin
                chk("t3_w0_valid", {63'd0, dump_valid}, 64'd1);
                chk("t3_w0_data", {32'd0, dump_data}, 64'h1000_0000);
            end
            if (c == 22) begin
                chk("t3_w1_valid", {63'd0, dump_valid}, 64'd1);
                chk("t3_w1_data", {32'd0, dump_data}, 64'h1000_0001);
            end
            step();
        end
        chk("t3_done", {63'd0, dump_done}, 64'd1);
        pl_req = 1'b0;
        step();

        // 4: backpressure on first word, start while busy ignored
        dump_ready = 1'b0;
        dump_lo = 32'h10; dump_hi = 32'h18; dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("t4_rd0_addr", {32'd0, mem_addr}, 64'h10);
        step(); step();
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", {63'd0, dump_valid}, 64'd1);
            chk("t4_hold_addr", {32'd0, dump_addr}, 64'h10);
            chk("t4_hold_data", {32'd0, dump_data}, 64'h1000_0004);
            chk("t4_no_read", {63'd0, mem_en}, 64'd0);
            if (k == 1) begin
                dump_lo = 32'h0; dump_hi = 32'h40; dump_start = 1'b1;
            end
            step();
            dump_start = 1'b0;
        end
        dump_ready = 1'b1;
        step();
        chk("t4_rd1_en", {63'd0, mem_en}, 64'd1);
        chk("t4_rd1_addr", {32'd0, mem_addr}, 64'h14);
        step(); step();
        chk("t4_w1_addr", {32'd0, dump_addr}, 64'h14);
        chk("t4_w1_data", {32'd0, dump_data}, 64'h1000_0005);
        step();
        chk("t4_done", {63'd0, dump_done}, 64'd1);
        step();

        // 5: store into the range while scanning
        scan(32'h0, 32'h10, 4, 1'b1, dc);
        chk("t5_done_cycle", 64'(dc), 64'd14);
        step();

        // 6: reset with a dump read in flight
        dump_lo = 32'h0; dump_hi = 32'h10; dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("t6_valid", {63'd0, dump_valid}, 64'd0);
        chk("t6_busy", {63'd0, dump_busy}, 64'd0);
        chk("t6_done", {63'd0, dump_done}, 64'd0);
        chk("t6_mem_en", {63'd0, mem_en}, 64'd0);
        chk("t6_dump_data", {32'd0, dump_data}, 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_quiet_done", {63'd0, dump_done}, 64'd0);
            chk("t6_quiet_valid", {63'd0, dump_valid}, 64'd0);
        end
        scan(32'h20, 32'h28, 2, 1'b0, dc);
        chk("t6_rescan_done_cycle", 64'(dc), 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
